// File: rtl/serial_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_adder_pkg : state encoding and elaboration helpers            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ceil(log2(n)), never less than 1 so a one-digit adder still has a counter bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit params_legal(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && (width % digit == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_ripple_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ripple_add : DIGIT-wide combinational ripple-carry adder             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ripple_add #(
  parameter int DIGIT = 4
) (
  input  logic             ci,
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  endgenerate

  assign co    = c[DIGIT];
  // carry into the top bit of the digit; on the last digit this is the MSB carry-in
  assign c_msb = c[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_adder : multi-cycle add/sub, DIGIT bits per clock, LSB first  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             ci,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = clog2_min1(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (!params_legal(WIDTH, DIGIT)) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] xa_q, xa_d;
  logic [WIDTH-1:0] yb_q, yb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last;
  logic [DIGIT-1:0] x_dig, y_dig, dsum;
  logic             dco, dcmsb;

  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last   = (cnt_q == LAST);

  always_comb begin
    x_dig = xa_q[cnt_q*DIGIT +: DIGIT];
    y_dig = yb_q[cnt_q*DIGIT +: DIGIT];
  end

  ripple_add #(
    .DIGIT (DIGIT)
  ) u_ripple (
    .ci    (carry_q),
    .x     (x_dig),
    .y     (y_dig),
    .s     (dsum),
    .co    (dco),
    .c_msb (dcmsb)
  );

  // State register plus datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      xa_q    <= '0;
      yb_q    <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      xa_q    <= xa_d;
      yb_q    <= yb_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last)  state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Partial sums build up in acc_q; s_q only changes on the final digit
  always_comb begin
    cnt_d   = cnt_q;
    carry_d = carry_q;
    xa_d    = xa_q;
    yb_d    = yb_q;
    acc_d   = acc_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    if (accept) begin
      xa_d    = x;
      yb_d    = y ^ {WIDTH{sub}};
      carry_d = sub ? 1'b1 : ci;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      acc_d[cnt_q*DIGIT +: DIGIT] = dsum;
      carry_d = dco;
      if (last) begin
        s_d   = acc_d;
        co_d  = dco;
        ovf_d = dco ^ dcmsb;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
    s    = s_q;
    co   = co_q;
    ovf  = ovf_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_adder : directed self-checking bench, WIDTH=16 DIGIT=4     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_serial_adder;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic             ci;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  int total = 0;
  int bad   = 0;

  serial_adder #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .ci    (ci),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation and check latency, pulse width and result.
  // With pulse_mid set, a stray start with x=0xAAAA is driven during RUN.
  task automatic run_op(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                        input logic civ, input logic subv, input logic [15:0] es,
                        input logic eco, input logic eovf, input bit pulse_mid);
    int cyc;
    @(negedge clk);
    x = xv; y = yv; ci = civ; sub = subv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 20) begin
      if (pulse_mid && cyc == 1) begin
        start = 1'b1; x = 16'hAAAA; y = 16'h5555; sub = 1'b0; ci = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_lat"}, 32'(cyc), 32'(N));
    check({tag, "_s"},   32'(s),   32'(es));
    check({tag, "_co"},  32'(co),  32'(eco));
    check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"},  32'(s),    32'(es));
  endtask

  initial begin
    int cyc;
    int pulses;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; ci = 1'b0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s",    32'(s),    32'd0);
    check("rst_co",   32'(co),   32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    rst_n = 1'b1;

    run_op("add",     16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
    run_op("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("wrap_ci", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
    run_op("sovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    // Reset two cycles into RUN: outputs clear at once, no done follows
    @(negedge clk);
    x = 16'h1234; y = 16'h1111; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_s",    32'(s),    32'd0);
    check("mid_co",   32'(co),   32'd0);
    check("mid_ovf",  32'(ovf),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("mid_no_done", 32'(pulses), 32'd0);
    run_op("after_rst", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);

    run_op("borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("ignore", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1);

    // Back-to-back: start held in the DONE cycle launches the next operation
    @(negedge clk);
    x = 16'h1234; y = 16'h1111; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_first_lat", 32'(cyc), 32'(N));
    check("b2b_first_s",   32'(s),   32'h2345);
    x = 16'h0005; y = 16'h0007; ci = 1'b1; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_accept_busy", 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc < 20) begin
      if (cyc == 3) check("b2b_hold_s", 32'(s), 32'h2345);
      @(negedge clk);
      cyc++;
    end
    check("b2b_second_lat", 32'(cyc), 32'(N + 1));
    check("b2b_second_s",   32'(s),   32'hFFFE);
    check("b2b_second_co",  32'(co),  32'd0);
    @(negedge clk);
    check("b2b_idle", 32'(done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
